mic1_core: RTL and testbench
============================

Name: mic1_core

Overview:
- Microprogrammed MIC-1 processor core (Tanenbaum IJVM datapath): 32-bit registers, ALU/shifter, microsequencer.
- Executes one 36-bit microinstruction per clock, read from an external synchronous control store (512 x 36).
- Accesses external synchronous dual-port main memory: word port for data, byte port for instruction fetch.
- Sits between control_store and main_memory in the SoC; TOS is exported for observation.

Parameters:
- PC_RESET, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mp_mem_addr  out  9  control-store read address.
- mp_mem_wdata  out  36  control-store write data; tied to 0.
- mp_mem_rdata  in  36  microinstruction, valid the cycle after its address is presented.
- mem_read  out  1  data word read strobe.
- mem_write  out  1  data word write strobe.
- mem_addr  out  32  data word address (MAR semantics).
- mem_wdata  out  32  data write value.
- mem_rdata  in  32  read data, valid the cycle after the read strobe.
- mem_fetch  out  1  instruction byte fetch strobe.
- mem_addr_instr  out  32  instruction byte address (PC).
- mem_rd_instr  in  8  fetched byte, valid the cycle after the fetch strobe.
- out  out  32  current TOS.

Behaviour:
- Registers: MAR, MDR, PC, MBR(8), SP, LV, CPP, TOS, OPC, H, plus internal started, rd_pend, fetch_pend.
- Reset: all registers and flags are 0 and PC = PC_RESET. While resetn is low, all strobes are 0 and mp_mem_addr = 0.
- First cycle after reset (started = 0): MIR is treated as all-zero (NOP), mp_mem_addr = 0, and started is set at the edge.
- Microinstruction fields (MIR = mp_mem_rdata when started):
  - [35:27] NEXT_ADDRESS; [26] JMPC; [25] JAMN; [24] JAMZ.
  - [23] SLL8; [22] SRA1; [21] F0; [20] F1; [19] ENA; [18] ENB; [17] INVA; [16] INC.
  - C enables [15:7] = H, OPC, TOS, CPP, LV, SP, PC, MDR, MAR.
  - [6] WRITE; [5] READ; [4] FETCH; [3:0] B select.
- B bus:
  - 0 MDR, 1 PC, 2 MBR sign-extended, 3 MBR zero-extended, 4 SP, 5 LV, 6 CPP, 7 TOS, 8 OPC.
  - 9-15 drive 0.
- A bus = H.
- ALU:
  - a = ENA ? A : 0; a' = INVA ? ~a : a; b = ENB ? B : 0.
  - F0F1 = 00: a' & b; 01: a' | b; 10: ~b; 11: a' + b + INC (mod 2^32). INC is ignored unless F0F1 = 11.
- Shifter: SLL8 gives ALU << 8; else SRA1 gives arithmetic >> 1; else pass-through. SLL8 has priority when both are set.
- Flags: N = ALU[31], Z = (ALU == 0). Both are taken from the unshifted ALU output of the current microinstruction.
- C bus: the shifter output is written at the edge to every enabled register (simultaneous multi-destination).
- Next address, combinational: addr = NEXT_ADDRESS.
  - If JMPC, addr[7:0] |= MBR.
  - addr[8] |= (JAMN & N) | (JAMZ & Z).
  - mp_mem_addr = addr, so the control store returns the next microinstruction at the same edge the registers update.
- Memory, combinational outputs:
  - mem_read = READ; mem_write = WRITE; mem_fetch = FETCH.
  - mem_addr = MAR_next (C value if MAR enabled, else MAR).
  - mem_wdata = MDR_next.
  - mem_addr_instr = PC_next.
- Read completion: a READ issued in microinstruction k sets rd_pend. At the end of k+1, MDR <= mem_rdata, overriding any C-bus write to MDR in k+1. The value is usable from k+2.
- Fetch completion: FETCH in k; at the end of k+1, MBR <= mem_rd_instr (overrides nothing else); usable from k+2. JMPC in k+1 uses the old MBR.
- Back-to-back reads or fetches are allowed; each completes one cycle after its strobe.
- READ and WRITE in the same microinstruction: WRITE is performed, READ is ignored.
- Reset mid-operation: pending flags are cleared and no completion occurs.
- No stall or wait input; memory is fixed one-cycle latency.
- out = TOS continuously.

Test Plan:
- Reset then release: cycle 1 has mp_mem_addr = 0 and no strobes; all registers are 0 and out = 0.
- Microword H = H+1 (ENB=0, ENA=1, INC=1, F0F1=11, C=H) looped three times, then TOS=H via B=none and A path -> out = 3.
- READ with MAR = SP = 5 and mem_rdata = 32'h0000_0041 -> mem_addr = 5 in k; MDR = 0x41 from k+2; TOS=MDR gives out = 0x41.
- WRITE with MAR = 32'hFFFF_FFFD and MDR = 0x48 in the same word -> mem_write = 1, mem_addr = FFFFFFFD, mem_wdata = 0x48 in that cycle.
- FETCH with PC = PC+1 from 0 and mem_rd_instr = 0x10 -> mem_addr_instr = 1. Next-but-one microword with JMPC and NEXT_ADDRESS = 0 -> mp_mem_addr = 0x010.
- JAMZ with ALU result 0 and NEXT_ADDRESS = 0x012 -> mp_mem_addr = 0x112. With result 0xFFFFFFFF under JAMN -> 0x112; under JAMZ -> 0x012.

Source files
------------

// File: rtl/mic1_core.sv
// rtl/mic1_core.sv - MIC-1 microprogrammed core: IJVM register file, ALU/shifter, microsequencer
// One microinstruction per clock; memory completions land one cycle after their strobe.
module mic1_core #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [8:0]  mp_mem_addr,
  output logic [35:0] mp_mem_wdata,
  input  logic [35:0] mp_mem_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_fetch,
  output logic [31:0] mem_addr_instr,
  input  logic [7:0]  mem_rd_instr,
  output logic [31:0] out
);

  logic [31:0] mar_q, mdr_q, pc_q, sp_q, lv_q, cpp_q, tos_q, opc_q, h_q;
  logic [31:0] mar_d, mdr_d, pc_d, sp_d, lv_d, cpp_d, tos_d, opc_d, h_d;
  logic [7:0]  mbr_q, mbr_d;
  logic        started_q, rd_pend_q, fetch_pend_q;
  logic        rd_pend_d, fetch_pend_d;

  logic [35:0] mir;
  logic [8:0]  next_addr, c_en, addr;
  logic        jmpc, jamn, jamz, sll8, sra1, f0, f1, ena, enb, inva, inc;
  logic        wr_bit, rd_bit, fe_bit;
  logic [3:0]  b_sel;
  logic [31:0] b_bus, a_v, b_v, alu, sh;
  logic        n_flag, z_flag;

  // Until the first microword has been requested, the control store output is meaningless.
  assign mir = started_q ? mp_mem_rdata : 36'd0;

  assign next_addr = mir[35:27];
  assign {jmpc, jamn, jamz} = mir[26:24];
  assign {sll8, sra1, f0, f1, ena, enb, inva, inc} = mir[23:16];
  assign c_en = mir[15:7];
  assign {wr_bit, rd_bit, fe_bit} = mir[6:4];
  assign b_sel = mir[3:0];

  always_comb begin
    b_bus = 32'd0;
    case (b_sel)
      4'd0: b_bus = mdr_q;
      4'd1: b_bus = pc_q;
      4'd2: b_bus = {{24{mbr_q[7]}}, mbr_q};
      4'd3: b_bus = {24'd0, mbr_q};
      4'd4: b_bus = sp_q;
      4'd5: b_bus = lv_q;
      4'd6: b_bus = cpp_q;
      4'd7: b_bus = tos_q;
      4'd8: b_bus = opc_q;
      default: b_bus = 32'd0;
    endcase
  end

  always_comb begin
    a_v = ena ? h_q : 32'd0;
    if (inva) a_v = ~a_v;
    b_v = enb ? b_bus : 32'd0;
    case ({f0, f1})
      2'b00:   alu = a_v & b_v;
      2'b01:   alu = a_v | b_v;
      2'b10:   alu = ~b_v;
      default: alu = a_v + b_v + {31'd0, inc};
    endcase
    if (sll8)      sh = {alu[23:0], 8'd0};
    else if (sra1) sh = {alu[31], alu[31:1]};
    else           sh = alu;
  end

  assign n_flag = alu[31];
  assign z_flag = (alu == 32'd0);

  always_comb begin
    addr = next_addr;
    if (jmpc) addr[7:0] = addr[7:0] | mbr_q;
    if ((jamn && n_flag) || (jamz && z_flag)) addr[8] = 1'b1;
  end

  always_comb begin
    h_d   = c_en[8] ? sh : h_q;
    opc_d = c_en[7] ? sh : opc_q;
    tos_d = c_en[6] ? sh : tos_q;
    cpp_d = c_en[5] ? sh : cpp_q;
    lv_d  = c_en[4] ? sh : lv_q;
    sp_d  = c_en[3] ? sh : sp_q;
    pc_d  = c_en[2] ? sh : pc_q;
    mdr_d = c_en[1] ? sh : mdr_q;
    mar_d = c_en[0] ? sh : mar_q;
    // A completing read beats the C bus for MDR.
    if (rd_pend_q) mdr_d = mem_rdata;
    mbr_d = fetch_pend_q ? mem_rd_instr : mbr_q;
    rd_pend_d    = rd_bit && !wr_bit;
    fetch_pend_d = fe_bit;
  end

  assign mp_mem_addr    = addr;
  assign mp_mem_wdata   = 36'd0;
  assign mem_read       = rd_bit && !wr_bit;
  assign mem_write      = wr_bit;
  assign mem_fetch      = fe_bit;
  assign mem_addr       = mar_d;
  assign mem_wdata      = mdr_d;
  assign mem_addr_instr = pc_d;
  assign out            = tos_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mar_q <= '0; mdr_q <= '0; pc_q <= PC_RESET; sp_q <= '0; lv_q <= '0;
      cpp_q <= '0; tos_q <= '0; opc_q <= '0; h_q <= '0; mbr_q <= '0;
      started_q <= 1'b0; rd_pend_q <= 1'b0; fetch_pend_q <= 1'b0;
    end else begin
      mar_q <= mar_d; mdr_q <= mdr_d; pc_q <= pc_d; sp_q <= sp_d; lv_q <= lv_d;
      cpp_q <= cpp_d; tos_q <= tos_d; opc_q <= opc_d; h_q <= h_d; mbr_q <= mbr_d;
      started_q <= 1'b1; rd_pend_q <= rd_pend_d; fetch_pend_q <= fetch_pend_d;
    end
  end

endmodule

// File: tb/tb_mic1_core.sv
// tb/tb_mic1_core.sv - directed and random checks of mic1_core against an instruction-level model
module tb_mic1_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [8:0]  mp_mem_addr;
  logic [35:0] mp_mem_wdata;
  logic [35:0] mp_mem_rdata = '0;
  logic        mem_read, mem_write, mem_fetch;
  logic [31:0] mem_addr, mem_wdata, mem_addr_instr, out;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  mem_rd_instr = '0;

  always #5 clk = ~clk;

  mic1_core #(.PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .resetn(resetn),
    .mp_mem_addr(mp_mem_addr), .mp_mem_wdata(mp_mem_wdata), .mp_mem_rdata(mp_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_fetch(mem_fetch), .mem_addr_instr(mem_addr_instr),
    .mem_rd_instr(mem_rd_instr), .out(out)
  );

  int total = 0;
  int bad = 0;

  localparam int MAR = 0, MDR = 1, PC = 2, SP = 3, TOS = 6, OPC = 7, HR = 8;
  localparam logic [8:0] C_MAR = 9'h001, C_MDR = 9'h002, C_PC = 9'h004, C_SP = 9'h008;
  localparam logic [8:0] C_TOS = 9'h040, C_OPC = 9'h080, C_H = 9'h100, C_NONE = 9'h000;
  localparam logic [2:0] M_WR = 3'b100, M_RD = 3'b010, M_FE = 3'b001;
  localparam logic [2:0] J_C = 3'b100, J_N = 3'b010, J_Z = 3'b001;
  // alu byte = {SLL8,SRA1,F0,F1,ENA,ENB,INVA,INC}
  localparam logic [7:0] A_INC_H = 8'h39, A_PASS_H = 8'h38, A_PASS_B = 8'h34;
  localparam logic [7:0] A_B_INC = 8'h35, A_ZERO = 8'h00, A_ONES = 8'h20, A_ADD = 8'h3C;

  // Reference machine state
  logic [31:0] r [0:8];
  logic [31:0] nx [0:8];
  logic [7:0]  mbr;
  logic        started, rdp, fp;
  logic [8:0]  e_addr;
  logic        e_rd, e_wr, e_fe;
  logic [8:0]  o_addr;
  logic        o_rd, o_wr, o_fe;
  logic [31:0] o_maddr, o_wdata, o_iaddr;

  function automatic logic [35:0] mw(input logic [8:0] na, input logic [2:0] jam,
                                     input logic [7:0] alu, input logic [8:0] c,
                                     input logic [2:0] mem, input logic [3:0] b);
    return {na, jam, alu, c, mem, b};
  endfunction

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) r[i] = 32'd0;
    mbr = 8'd0; started = 1'b0; rdp = 1'b0; fp = 1'b0;
  endtask

  task automatic model_eval(input logic [35:0] w, input logic [31:0] rd);
    logic [35:0] m;
    logic [31:0] bb, a, b, alu, sh;
    m = started ? w : 36'd0;
    case (m[3:0])
      4'd0: bb = r[MDR];
      4'd1: bb = r[PC];
      4'd2: bb = 32'($signed(mbr));
      4'd3: bb = 32'(mbr);
      4'd4: bb = r[3];
      4'd5: bb = r[4];
      4'd6: bb = r[5];
      4'd7: bb = r[TOS];
      4'd8: bb = r[OPC];
      default: bb = 32'd0;
    endcase
    a = m[19] ? r[HR] : 32'd0;
    if (m[17]) a = ~a;
    b = m[18] ? bb : 32'd0;
    case (m[21:20])
      2'd0: alu = a & b;
      2'd1: alu = a | b;
      2'd2: alu = ~b;
      default: alu = a + b + 32'(m[16]);
    endcase
    if (m[23])      sh = alu << 8;
    else if (m[22]) sh = 32'($signed(alu) >>> 1);
    else            sh = alu;
    e_addr = m[35:27];
    if (m[26]) e_addr[7:0] = e_addr[7:0] | mbr;
    if ((m[25] && alu[31]) || (m[24] && alu == 32'd0)) e_addr[8] = 1'b1;
    for (int i = 0; i < 9; i++) nx[i] = m[7 + i] ? sh : r[i];
    if (rdp) nx[MDR] = rd;
    e_wr = m[6];
    e_rd = m[5] && !m[6];
    e_fe = m[4];
  endtask

  task automatic model_commit(input logic [7:0] ins);
    for (int i = 0; i < 9; i++) r[i] = nx[i];
    if (fp) mbr = ins;
    rdp = e_rd; fp = e_fe; started = 1'b1;
  endtask

  task automatic step(input logic [35:0] w, input logic [31:0] rd, input logic [7:0] ins);
    @(negedge clk);
    mp_mem_rdata = w; mem_rdata = rd; mem_rd_instr = ins;
    #1;
    model_eval(w, rd);
    o_addr = mp_mem_addr; o_rd = mem_read; o_wr = mem_write; o_fe = mem_fetch;
    o_maddr = mem_addr; o_wdata = mem_wdata; o_iaddr = mem_addr_instr;
    chk("mp_mem_addr", 36'(o_addr), 36'(e_addr));
    chk("strobes", 36'({o_rd, o_wr, o_fe}), 36'({e_rd, e_wr, e_fe}));
    chk("mem_addr", 36'(o_maddr), 36'(nx[MAR]));
    chk("mem_wdata", 36'(o_wdata), 36'(nx[MDR]));
    chk("mem_addr_instr", 36'(o_iaddr), 36'(nx[PC]));
    chk("out", 36'(out), 36'(r[TOS]));
    @(posedge clk);
    model_commit(ins);
  endtask

  initial begin
    model_reset();
    mp_mem_rdata = mw(9'h1AB, J_C, A_ONES, C_H, M_RD | M_FE, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_mp_addr", 36'(mp_mem_addr), 36'd0);
    chk("rst_strobes", 36'({mem_read, mem_write, mem_fetch}), 36'd0);
    chk("rst_out", 36'(out), 36'd0);
    chk("mp_wdata", mp_mem_wdata, 36'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // First cycle: control store output ignored
    step(mw(9'h1FF, J_C | J_N, A_ONES, C_H | C_TOS, M_WR | M_FE, 4'd1), 32'h1234, 8'hAA);
    chk("c1_addr", 36'(o_addr), 36'd0);
    chk("c1_strobes", 36'({o_rd, o_wr, o_fe}), 36'd0);

    repeat (3) step(mw(9'd0, 3'd0, A_INC_H, C_H, 3'd0, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_PASS_H, C_TOS, 3'd0, 4'd15), 32'd0, 8'd0);
    #2 chk("out_3", 36'(out), 36'd3);

    // H=5, SP=H, MAR=SP with READ
    repeat (2) step(mw(9'd0, 3'd0, A_INC_H, C_H, 3'd0, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_PASS_H, C_SP, 3'd0, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_PASS_B, C_MAR, M_RD, 4'd4), 32'd0, 8'd0);
    chk("rd_addr", 36'(o_maddr), 36'd5);
    chk("rd_strobe", 36'(o_rd), 36'd1);
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, 3'd0, 4'd15), 32'h0000_0041, 8'd0);
    step(mw(9'd0, 3'd0, A_PASS_B, C_TOS, 3'd0, 4'd0), 32'd0, 8'd0);
    #2 chk("out_41", 36'(out), 36'h41);

    // MDR=0x48 by read, then MAR=-3 together with WRITE
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, M_RD, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, 3'd0, 4'd15), 32'h0000_0048, 8'd0);
    step(mw(9'd0, 3'd0, A_ONES, C_OPC, 3'd0, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_ONES, C_H, 3'd0, 4'd15), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_ADD, C_H, 3'd0, 4'd8), 32'd0, 8'd0);
    step(mw(9'd0, 3'd0, A_ADD, C_MAR, M_WR, 4'd8), 32'd0, 8'd0);
    chk("wr_strobe", 36'(o_wr), 36'd1);
    chk("wr_addr", 36'(o_maddr), 36'hFFFF_FFFD);
    chk("wr_data", 36'(o_wdata), 36'h48);

    // FETCH then JMPC: k+1 still sees old MBR
    step(mw(9'd0, 3'd0, A_B_INC, C_PC, M_FE, 4'd1), 32'd0, 8'd0);
    chk("fe_iaddr", 36'(o_iaddr), 36'd1);
    chk("fe_strobe", 36'(o_fe), 36'd1);
    step(mw(9'h020, J_C, A_ZERO, C_NONE, 3'd0, 4'd15), 32'd0, 8'h10);
    chk("jmpc_old", 36'(o_addr), 36'h020);
    step(mw(9'h000, J_C, A_ZERO, C_NONE, 3'd0, 4'd15), 32'd0, 8'd0);
    chk("jmpc_new", 36'(o_addr), 36'h010);

    step(mw(9'h012, J_Z, A_ZERO, C_NONE, 3'd0, 4'd15), 32'd0, 8'd0);
    chk("jamz_0", 36'(o_addr), 36'h112);
    step(mw(9'h012, J_N, A_ONES, C_NONE, 3'd0, 4'd15), 32'd0, 8'd0);
    chk("jamn_neg", 36'(o_addr), 36'h112);
    step(mw(9'h012, J_Z, A_ONES, C_NONE, 3'd0, 4'd15), 32'd0, 8'd0);
    chk("jamz_nz", 36'(o_addr), 36'h012);

    // READ with WRITE: read dropped, MDR must not load
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, M_WR | M_RD, 4'd15), 32'd0, 8'd0);
    chk("rw_strobes", 36'({o_rd, o_wr}), 36'b01);
    step(mw(9'd0, 3'd0, A_PASS_B, C_TOS, 3'd0, 4'd0), 32'hCAFE_F00D, 8'd0);
    step(mw(9'd0, 3'd0, A_PASS_B, C_TOS, 3'd0, 4'd0), 32'd0, 8'd0);
    #2 chk("rw_mdr_kept", 36'(out), 36'h48);

    for (int i = 0; i < 400; i++)
      step(36'({$urandom, $urandom}), $urandom, 8'($urandom));

    // Reset while a read is pending: no completion
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, M_RD | M_FE, 4'd15), 32'd0, 8'd0);
    #2 resetn = 1'b0;
    mem_rdata = 32'hDEAD_BEEF; mem_rd_instr = 8'h77;
    #1;
    chk("mid_rst_addr", 36'(mp_mem_addr), 36'd0);
    chk("mid_rst_strobes", 36'({mem_read, mem_write, mem_fetch}), 36'd0);
    @(posedge clk); #2;
    resetn = 1'b1;
    model_reset();
    step(mw(9'd0, 3'd0, A_ZERO, C_NONE, 3'd0, 4'd15), 32'hDEAD_BEEF, 8'h77);
    step(mw(9'd0, 3'd0, A_PASS_B, C_TOS, 3'd0, 4'd0), 32'hDEAD_BEEF, 8'h77);
    step(mw(9'd0, 3'd0, A_PASS_B, C_TOS, 3'd0, 4'd3), 32'd0, 8'd0);
    #2 chk("mid_rst_out", 36'(out), 36'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
